blockram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer that shares one single-port `BlockRAM` instance (1-cycle registered read, no read-during-write data) between two clients. Each client issues reads/writes over a valid/ready request channel and receives read data over a valid/ready response channel backed by a one-entry buffer. The block sits between the client pipelines and the RAM ports: it drives `ADDR`/`DI`/`WE`/`RE` and consumes `DO`.

---
 rtl/blockram_arbiter_if.sv | 48 ++++
 rtl/blockram_arbiter.sv | 129 ++++++++++++
 tb/tb_blockram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blockram_arbiter_if.sv
// Request, response and RAM-port bundle for the two-client BlockRAM arbiter.
// slave = arbiter side, master = clients plus the attached RAM.
interface blockram_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  REQ0_VALID;
    logic                  REQ0_READY;
    logic                  REQ0_WE;
    logic [ADDR_WIDTH-1:0] REQ0_ADDR;
    logic [DATA_WIDTH-1:0] REQ0_DI;
    logic                  RESP0_VALID;
    logic                  RESP0_READY;
    logic [DATA_WIDTH-1:0] RESP0_DO;

    logic                  REQ1_VALID;
    logic                  REQ1_READY;
    logic                  REQ1_WE;
    logic [ADDR_WIDTH-1:0] REQ1_ADDR;
    logic [DATA_WIDTH-1:0] REQ1_DI;
    logic                  RESP1_VALID;
    logic                  RESP1_READY;
    logic [DATA_WIDTH-1:0] RESP1_DO;

    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DI;
    logic                  RAM_WE;
    logic                  RAM_RE;
    logic [DATA_WIDTH-1:0] RAM_DO;

    modport slave (
        input  REQ0_VALID, REQ0_WE, REQ0_ADDR, REQ0_DI, RESP0_READY,
        input  REQ1_VALID, REQ1_WE, REQ1_ADDR, REQ1_DI, RESP1_READY,
        output REQ0_READY, RESP0_VALID, RESP0_DO,
        output REQ1_READY, RESP1_VALID, RESP1_DO,
        output RAM_ADDR, RAM_DI, RAM_WE, RAM_RE,
        input  RAM_DO
    );

    modport master (
        output REQ0_VALID, REQ0_WE, REQ0_ADDR, REQ0_DI, RESP0_READY,
        output REQ1_VALID, REQ1_WE, REQ1_ADDR, REQ1_DI, RESP1_READY,
        input  REQ0_READY, RESP0_VALID, RESP0_DO,
        input  REQ1_READY, RESP1_VALID, RESP1_DO,
        input  RAM_ADDR, RAM_DI, RAM_WE, RAM_RE,
        output RAM_DO
    );
endinterface

// File: rtl/blockram_arbiter.sv
// Round-robin arbiter sharing one single-port BlockRAM between two clients,
// with one in-flight read and a one-entry response buffer per client.
module blockram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    blockram_arbiter_if.slave bus
);

    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [1:0]            resp_ready;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0] req_di   [2];

    assign req_valid     = {bus.REQ1_VALID, bus.REQ0_VALID};
    assign req_we        = {bus.REQ1_WE, bus.REQ0_WE};
    assign resp_ready    = {bus.RESP1_READY, bus.RESP0_READY};
    assign req_addr[0]   = bus.REQ0_ADDR;
    assign req_addr[1]   = bus.REQ1_ADDR;
    assign req_di[0]     = bus.REQ0_DI;
    assign req_di[1]     = bus.REQ1_DI;

    logic                  prio_q, prio_d;
    logic                  infl_v_q, infl_v_d;
    logic                  infl_id_q, infl_id_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_do_q [2];
    logic [DATA_WIDTH-1:0] resp_do_d [2];

    logic [1:0] own_infl;
    logic [1:0] elig_wr;
    logic [1:0] elig_rd;
    logic [1:0] elig;
    logic       gnt_v;
    logic       gnt_id;

    // A read needs a free (or draining) buffer and no read of its own in flight.
    always_comb begin
        own_infl = {infl_v_q & infl_id_q, infl_v_q & ~infl_id_q};
        elig_wr  = req_valid & req_we;
        elig_rd  = req_valid & ~req_we
                 & (~resp_valid_q | resp_ready)
                 & ~own_infl;
        elig     = elig_wr | elig_rd;
    end

    always_comb begin
        gnt_v  = |elig;
        gnt_id = elig[1];
        if (&elig) begin
            gnt_id = prio_q;
        end
    end

    logic [1:0]            req_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_di;
    logic                  ram_we;
    logic                  ram_re;

    // Outputs are held quiet for as long as reset is asserted.
    always_comb begin
        req_ready = '0;
        ram_addr  = '0;
        ram_di    = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        if (gnt_v && RST_N) begin
            req_ready[gnt_id] = 1'b1;
            ram_addr          = req_addr[gnt_id];
            ram_di            = req_di[gnt_id];
            ram_we            = req_we[gnt_id];
            ram_re            = ~req_we[gnt_id];
        end
    end

    always_comb begin
        prio_d       = prio_q;
        infl_v_d     = 1'b0;
        infl_id_d    = infl_id_q;
        resp_valid_d = resp_valid_q & ~resp_ready;
        resp_do_d    = resp_do_q;
        if (gnt_v) begin
            prio_d = ~gnt_id;
            if (!req_we[gnt_id]) begin
                infl_v_d  = 1'b1;
                infl_id_d = gnt_id;
            end
        end
        // Capture after dequeue so a same-edge capture keeps the buffer full.
        if (infl_v_q) begin
            resp_valid_d[infl_id_q] = 1'b1;
            resp_do_d[infl_id_q]    = bus.RAM_DO;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio_q       <= 1'b0;
            infl_v_q     <= 1'b0;
            infl_id_q    <= 1'b0;
            resp_valid_q <= '0;
            resp_do_q[0] <= '0;
            resp_do_q[1] <= '0;
        end else begin
            prio_q       <= prio_d;
            infl_v_q     <= infl_v_d;
            infl_id_q    <= infl_id_d;
            resp_valid_q <= resp_valid_d;
            resp_do_q[0] <= resp_do_d[0];
            resp_do_q[1] <= resp_do_d[1];
        end
    end

    assign bus.REQ0_READY  = req_ready[0];
    assign bus.REQ1_READY  = req_ready[1];
    assign bus.RESP0_VALID = resp_valid_q[0];
    assign bus.RESP1_VALID = resp_valid_q[1];
    assign bus.RESP0_DO    = resp_do_q[0];
    assign bus.RESP1_DO    = resp_do_q[1];
    assign bus.RAM_ADDR    = ram_addr;
    assign bus.RAM_DI      = ram_di;
    assign bus.RAM_WE      = ram_we;
    assign bus.RAM_RE      = ram_re;

endmodule

// File: tb/tb_blockram_arbiter.sv
// Bench for blockram_arbiter: behavioural BlockRAM, a read-data scoreboard
// per client, and directed timing checks.
module tb_blockram_arbiter;

    logic clk;
    logic rst_n;

    blockram_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    blockram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int n_cmp = 0;
    int n_err = 0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_DI;
        if (bus.RAM_RE) bus.RAM_DO <= mem[bus.RAM_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected read data queued at grant, compared at dequeue.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.REQ0_READY || bus.REQ1_READY) begin
                check("one_grant", {31'd0, bus.REQ0_READY & bus.REQ1_READY}, 0);
                check("we_re_excl", {31'd0, bus.RAM_WE & bus.RAM_RE}, 0);
            end
            if (bus.REQ0_READY) begin
                check("ram_addr0", bus.RAM_ADDR, bus.REQ0_ADDR);
                if (bus.REQ0_WE) ref_mem[bus.REQ0_ADDR] = bus.REQ0_DI;
                else q0.push_back(ref_mem[bus.REQ0_ADDR]);
            end
            if (bus.REQ1_READY) begin
                check("ram_addr1", bus.RAM_ADDR, bus.REQ1_ADDR);
                if (bus.REQ1_WE) ref_mem[bus.REQ1_ADDR] = bus.REQ1_DI;
                else q1.push_back(ref_mem[bus.REQ1_ADDR]);
            end
            if (bus.RESP0_VALID && bus.RESP0_READY) begin
                if (q0.size() == 0) check("resp0_unexp", 1, 0);
                else check("resp0_do", bus.RESP0_DO, q0.pop_front());
            end
            if (bus.RESP1_VALID && bus.RESP1_READY) begin
                if (q1.size() == 0) check("resp1_unexp", 1, 0);
                else check("resp1_do", bus.RESP1_DO, q1.pop_front());
            end
        end
    end

    task automatic set_req(input int n, input logic v, input logic we,
                           input int a, input logic [31:0] d);
        logic [9:0] a10;
        a10 = a[9:0];
        if (n == 0) begin
            bus.REQ0_VALID = v;
            bus.REQ0_WE    = we;
            bus.REQ0_ADDR  = a10;
            bus.REQ0_DI    = d;
        end else begin
            bus.REQ1_VALID = v;
            bus.REQ1_WE    = we;
            bus.REQ1_ADDR  = a10;
            bus.REQ1_DI    = d;
        end
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        bus.RESP0_READY = 1'b1;
        bus.RESP1_READY = 1'b1;
        #1;
        rst_n = 1'b0;
        set_req(0, 1, 1, 9, 32'h99);
        set_req(1, 1, 0, 9, 0);
        @(negedge clk);
        check("rst_ready0", bus.REQ0_READY, 0);
        check("rst_ready1", bus.REQ1_READY, 0);
        check("rst_we", bus.RAM_WE, 0);
        check("rst_re", bus.RAM_RE, 0);
        check("rst_addr", bus.RAM_ADDR, 0);
        check("rst_di", bus.RAM_DI, 0);
        check("rst_resp0_v", bus.RESP0_VALID, 0);
        check("rst_resp1_do", bus.RESP1_DO, 0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // write then read back, 2-cycle read latency
        set_req(0, 1, 1, 5, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_ready", bus.REQ0_READY, 1);
        check("wr_we", bus.RAM_WE, 1);
        tick();
        set_req(0, 1, 0, 5, 0);
        @(negedge clk);
        check("rd_ready", bus.REQ0_READY, 1);
        check("rd_re", bus.RAM_RE, 1);
        tick();
        idle();
        @(negedge clk);
        check("rd_t2_valid", bus.RESP0_VALID, 0);
        tick();
        @(negedge clk);
        check("rd_t3_valid", bus.RESP0_VALID, 1);
        check("rd_t3_do", bus.RESP0_DO, 32'hDEADBEEF);
        tick();

        // contention: strict alternation starting at requester 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1, 1, 16 + i, 32'hA0 + i);
            set_req(1, 1, 1, 32 + i, 32'hB0 + i);
            @(negedge clk);
            check("cont_ready0", bus.REQ0_READY, (i % 2) == 0);
            check("cont_ready1", bus.REQ1_READY, (i % 2) == 1);
            check("cont_we", bus.RAM_WE, 1);
            tick();
        end
        idle();

        // response backpressure on 0 must not block requester 1
        set_req(0, 1, 1, 1, 32'h1111);
        tick();
        bus.RESP0_READY = 1'b0;
        set_req(0, 1, 0, 1, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);
        check("bp_first_rd", bus.REQ0_READY, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) set_req(1, 1, 1, 40 + i, 32'hC0 + i);
            else set_req(1, 1, 0, 40 + i - 1, 0);
            @(negedge clk);
            check("bp_ready0", bus.REQ0_READY, 0);
            check("bp_ready1", bus.REQ1_READY, 1);
            if (i >= 1) begin
                check("bp_valid", bus.RESP0_VALID, 1);
                check("bp_do", bus.RESP0_DO, 32'h1111);
            end
            tick();
        end
        idle();
        bus.RESP0_READY = 1'b1;
        @(negedge clk);
        check("bp_hold_valid", bus.RESP0_VALID, 1);
        check("bp_hold_do", bus.RESP0_DO, 32'h1111);
        tick();
        @(negedge clk);
        check("bp_drained", bus.RESP0_VALID, 0);
        tick();

        // back-to-back reads with same-edge capture and dequeue
        set_req(0, 1, 1, 2, 32'h22);
        tick();
        set_req(0, 1, 1, 3, 32'h33);
        tick();
        set_req(0, 1, 0, 2, 0);
        @(negedge clk);
        check("b2b_t0_ready", bus.REQ0_READY, 1);
        tick();
        set_req(0, 1, 0, 3, 0);
        @(negedge clk);
        check("b2b_t1_ready", bus.REQ0_READY, 0);
        tick();
        @(negedge clk);
        check("b2b_t2_ready", bus.REQ0_READY, 1);
        check("b2b_t2_valid", bus.RESP0_VALID, 1);
        check("b2b_t2_do", bus.RESP0_DO, 32'h22);
        tick();
        idle();
        tick();
        @(negedge clk);
        check("b2b_t4_valid", bus.RESP0_VALID, 1);
        check("b2b_t4_do", bus.RESP0_DO, 32'h33);
        tick();

        // reset while a read is in flight
        do_reset();
        set_req(1, 1, 0, 2, 0);
        @(negedge clk);
        check("mid_rd_ready", bus.REQ1_READY, 1);
        tick();
        rst_n = 1'b0;
        set_req(0, 1, 1, 60, 32'h60);
        @(negedge clk);
        check("mid_ready0", bus.REQ0_READY, 0);
        check("mid_ready1", bus.REQ1_READY, 0);
        check("mid_we", bus.RAM_WE, 0);
        check("mid_re", bus.RAM_RE, 0);
        check("mid_addr", bus.RAM_ADDR, 0);
        check("mid_di", bus.RAM_DI, 0);
        check("mid_resp1_v", bus.RESP1_VALID, 0);
        tick();
        tick();
        rst_n = 1'b1;
        set_req(0, 1, 1, 50, 32'h50);
        set_req(1, 1, 1, 51, 32'h51);
        @(negedge clk);
        check("post_rst_ready0", bus.REQ0_READY, 1);
        check("post_rst_ready1", bus.REQ1_READY, 0);
        check("post_rst_v0", bus.RESP1_VALID, 0);
        tick();
        idle();
        @(negedge clk);
        check("post_rst_v1", bus.RESP1_VALID, 0);
        tick();
        @(negedge clk);
        check("post_rst_v2", bus.RESP1_VALID, 0);
        tick();

        // read-after-write to one address under contention
        do_reset();
        set_req(0, 1, 1, 7, 32'h1);
        set_req(1, 1, 0, 7, 0);
        @(negedge clk);
        check("raw_ready0", bus.REQ0_READY, 1);
        check("raw_ready1", bus.REQ1_READY, 0);
        check("raw_we", bus.RAM_WE, 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        check("raw_rd_ready1", bus.REQ1_READY, 1);
        check("raw_rd_addr", bus.RAM_ADDR, 7);
        tick();
        idle();
        tick();
        @(negedge clk);
        check("raw_valid", bus.RESP1_VALID, 1);
        check("raw_do", bus.RESP1_DO, 32'h1);
        tick();

        repeat (4) tick();
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
